// File: rtl/tl_ram_target.sv
// rtl/tl_ram_target.sv - TileLink-UL single-beat RAM target with one-entry response stage (optional stats: TL_RAM_STATS_EN)
module tl_ram_target #(
    parameter int ADDR_W = 26,
    parameter int SRC_W = 10,
    parameter int DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 26'h0010000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              auto_in_a_ready,
    input  logic              auto_in_a_valid,
    input  logic [2:0]        auto_in_a_bits_opcode,
    input  logic [2:0]        auto_in_a_bits_param,
    input  logic [1:0]        auto_in_a_bits_size,
    input  logic [SRC_W-1:0]  auto_in_a_bits_source,
    input  logic [ADDR_W-1:0] auto_in_a_bits_address,
    input  logic [3:0]        auto_in_a_bits_mask,
    input  logic [31:0]       auto_in_a_bits_data,
    input  logic              auto_in_a_bits_corrupt,
    input  logic              auto_in_d_ready,
    output logic              auto_in_d_valid,
    output logic [2:0]        auto_in_d_bits_opcode,
    output logic [1:0]        auto_in_d_bits_size,
    output logic [SRC_W-1:0]  auto_in_d_bits_source,
    output logic              auto_in_d_bits_denied,
    output logic [31:0]       auto_in_d_bits_data,
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_writes,
    output logic [15:0]       stat_denied
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Clears the in-window offset bits so the remainder can be compared to the base.
    localparam logic [ADDR_W-1:0] REGION_MASK = ~(ADDR_W'((4 << DEPTH_LOG2) - 1));

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ram_q;
    logic [31:0] hold_q;

    logic             s1_valid;
    logic [2:0]       s1_opcode;
    logic [1:0]       s1_size;
    logic [SRC_W-1:0] s1_source;
    logic             s1_denied;
    logic             s1_fresh;
    logic             s1_has_data;

    logic                  a_fire;
    logic                  d_fire;
    logic                  in_range;
    logic                  op_ok;
    logic                  is_get;
    logic                  req_denied;
    logic                  ram_wr;
    logic                  ram_rd;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  unused_param;

    assign unused_param = ^auto_in_a_bits_param;

    // The stage can take a new request whenever it is empty or draining this cycle.
    assign auto_in_a_ready = !s1_valid || auto_in_d_ready;
    assign a_fire = auto_in_a_valid && auto_in_a_ready;
    assign d_fire = s1_valid && auto_in_d_ready;

    assign in_range = (auto_in_a_bits_address & REGION_MASK) == BASE_ADDR;
    assign op_ok = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                   (auto_in_a_bits_opcode == OP_PUT_PARTIAL) ||
                   (auto_in_a_bits_opcode == OP_GET);
    assign is_get = auto_in_a_bits_opcode == OP_GET;
    assign req_denied = !in_range || (auto_in_a_bits_size == 2'd3) || !op_ok;
    assign word_idx = auto_in_a_bits_address[DEPTH_LOG2+1:2];

    // A Put seen while reset is asserted must not modify memory.
    assign ram_wr = a_fire && reset && !is_get && !req_denied && !auto_in_a_bits_corrupt;
    assign ram_rd = a_fire && is_get && !req_denied;

    // Byte-masked write port and registered read port; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (auto_in_a_bits_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
                end
            end
        end
        if (ram_rd) begin
            ram_q <= mem[word_idx];
        end
    end

    // Response stage: reload on accept, empty on completion, dropped by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_opcode <= 3'd0;
            s1_size   <= 2'd0;
            s1_source <= '0;
            s1_denied <= 1'b0;
            s1_fresh  <= 1'b0;
        end else begin
            s1_fresh <= a_fire;
            if (a_fire) begin
                s1_valid  <= 1'b1;
                s1_opcode <= is_get ? OP_ACK_DATA : OP_ACK;
                s1_size   <= auto_in_a_bits_size;
                s1_source <= auto_in_a_bits_source;
                s1_denied <= req_denied;
            end else if (d_fire) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Freeze the RAM word once the first response cycle has passed.
    always_ff @(posedge clock) begin
        if (s1_fresh) begin
            hold_q <= ram_q;
        end
    end

    // Only a granted Get carries data; the fresh cycle reads the RAM port directly.
    assign s1_has_data = (s1_opcode == OP_ACK_DATA) && !s1_denied;

    assign auto_in_d_valid       = s1_valid;
    assign auto_in_d_bits_opcode = s1_opcode;
    assign auto_in_d_bits_size   = s1_size;
    assign auto_in_d_bits_source = s1_source;
    assign auto_in_d_bits_denied = s1_denied;
    assign auto_in_d_bits_data   = !s1_has_data ? 32'd0 : (s1_fresh ? ram_q : hold_q);

`ifdef TL_RAM_STATS_EN
    logic [15:0] reads_q;
    logic [15:0] writes_q;
    logic [15:0] denied_q;

    // Saturating counters advance on response completion.
    always_ff @(posedge clock) begin
        if (!reset) begin
            reads_q  <= 16'd0;
            writes_q <= 16'd0;
            denied_q <= 16'd0;
        end else if (d_fire) begin
            if (s1_denied) begin
                if (denied_q != 16'hFFFF) denied_q <= denied_q + 16'd1;
            end else if (s1_opcode == OP_ACK_DATA) begin
                if (reads_q != 16'hFFFF) reads_q <= reads_q + 16'd1;
            end else begin
                if (writes_q != 16'hFFFF) writes_q <= writes_q + 16'd1;
            end
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_denied = denied_q;
`else
    assign stat_reads  = 16'd0;
    assign stat_writes = 16'd0;
    assign stat_denied = 16'd0;
`endif

endmodule
